// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and ratio limits.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/phase_cnt4.sv
// Two-bit wrapping counter of divided periods; advances once per asserted inc.
module phase_cnt4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (inc) begin
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider producing a registered divided waveform, a period tick
// and a period counter, with a ready/valid port for changing the ratio on period boundaries.
module clk_div_prog #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [1:0]       po_cnt
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_R   = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_R   = CNT_W'(DEF_DIV);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_act, div_act_nxt;
    logic [CNT_W-1:0] div_pend, div_pend_nxt;
    logic             xfer, legal, wrap, active_nxt;

    assign cfg_ready = (st != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = xfer && (cfg_div >= MIN_R);
    assign wrap      = (cnt == div_act - ONE);

    always_comb begin
        st_nxt       = st;
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        div_pend_nxt = div_pend;
        case (st)
            IDLE: begin
                cnt_nxt = '0;
                if (legal) div_act_nxt = cfg_div;
                if (en)    st_nxt      = RUN;
            end
            RUN: begin
                if (!en) begin
                    // A ratio offered on the falling edge of en takes effect on the next run.
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                    if (legal) div_act_nxt = cfg_div;
                end else begin
                    cnt_nxt = wrap ? '0 : cnt + ONE;
                    if (legal) begin
                        div_pend_nxt = cfg_div;
                        st_nxt       = PEND;
                    end
                end
            end
            PEND: begin
                if (!en) begin
                    st_nxt      = IDLE;
                    cnt_nxt     = '0;
                    div_act_nxt = div_pend;
                end else if (wrap) begin
                    st_nxt      = RUN;
                    cnt_nxt     = '0;
                    div_act_nxt = div_pend;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    assign active_nxt = (st_nxt != IDLE);

    // Outputs are registered from next-state values so they describe the state they enter with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= '0;
            div_act  <= DEF_R;
            div_pend <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            div_act  <= div_act_nxt;
            div_pend <= div_pend_nxt;
            clk_out  <= active_nxt && (cnt_nxt < (div_act_nxt >> 1));
            tick     <= active_nxt && (cnt_nxt == '0);
            cfg_err  <= xfer && (cfg_div < MIN_R);
        end
    end

    phase_cnt4 u_phase_cnt4 (
        .clk (clk),
        .rst (rst),
        .inc (tick),
        .cnt (po_cnt)
    );

endmodule
